csr_unit: RTL and testbench

Machine-mode control and status register file for the RV32I pipeline. Responds to the combinational CSR read port driven from the decode stage and accepts CSR writes from the MEM stage. Owns the machine trap state: ECALL, EBREAK and MRET entry and return, with a registered PC redirect to the fetch stage. Also maintains the 64-bit cycle and instret counters.

---
 rtl/csr_unit.sv | 212 +++++++++++++++++++++
 tb/tb_csr_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR file for the RV32I pipeline.
// Provides a combinational read port with write bypass, a MEM-stage write
// port, ECALL/EBREAK/MRET trap handling with a registered fetch redirect,
// and the 64-bit mcycle/minstret counters.

package csr_unit_pkg;
   typedef enum logic [1:0] {
      NO_TRAP = 2'd0,
      ECALL   = 2'd1,
      EBREAK  = 2'd2,
      MRET    = 2'd3
   } exc_t;
endpackage

module csr_unit
   import csr_unit_pkg::*;
#(
   parameter logic [31:0] HART_ID     = 32'h0000_0000,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        csr_re_i,
   input  logic [11:0] csr_raddr_i,
   output logic [31:0] csr_rdata_o,
   input  logic        csr_we_i,
   input  logic [11:0] csr_waddr_i,
   input  logic [31:0] csr_wdata_i,
   input  logic        instr_ret_i,
   input  exc_t        trap_i,
   input  logic [31:0] trap_pc_i,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;
   localparam logic [11:0] A_NONE      = 12'h000;

   localparam logic [31:0] MISA_VAL    = 32'h4000_0100;
   localparam logic [31:0] CAUSE_ECALL = 32'd11;
   localparam logic [31:0] CAUSE_EBRK  = 32'd3;

   // Assemble mstatus from its two live bits; MPP is hardwired to machine mode.
   function automatic logic [31:0] mstatus_view(input logic mpie, input logic mie);
      return {19'h0, 2'b11, 3'b000, mpie, 3'b000, mie, 3'b000};
   endfunction

   // True for addresses that accept software writes.
   function automatic logic is_writable(input logic [11:0] addr);
      logic ok;
      case (addr)
         A_MSTATUS, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
         A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: ok = 1'b1;
         default:                                     ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Value a writable CSR reads back after taking data, masks applied.
   function automatic logic [31:0] write_view(input logic [11:0] addr, input logic [31:0] data);
      logic [31:0] v;
      case (addr)
         A_MSTATUS:      v = mstatus_view(data[7], data[3]);
         A_MTVEC, A_MEPC: v = {data[31:2], 2'b00};
         default:        v = data;
      endcase
      return v;
   endfunction

   logic        mie_r, mpie_r;
   logic [29:0] mtvec_r, mepc_r;
   logic [31:0] mscratch_r, mcause_r, mtval_r;
   logic [63:0] mcycle_r, minstret_r;
   logic        redirect_r;
   logic [31:0] redirect_pc_r;

   logic        mie_nxt_s, mpie_nxt_s;
   logic [29:0] mtvec_nxt_s, mepc_nxt_s;
   logic [31:0] mscratch_nxt_s, mcause_nxt_s, mtval_nxt_s;
   logic [63:0] mcycle_nxt_s, minstret_nxt_s;
   logic        redirect_nxt_s;
   logic [31:0] redirect_pc_nxt_s;
   logic [11:0] wr_addr_s;
   logic [31:0] rd_reg_s;
   logic        byp_hit_s;

   // Next-state: counters advance, software writes apply, then trap updates override.
   always_comb begin
      wr_addr_s         = csr_we_i ? csr_waddr_i : A_NONE;
      mie_nxt_s         = mie_r;
      mpie_nxt_s        = mpie_r;
      mtvec_nxt_s       = mtvec_r;
      mepc_nxt_s        = mepc_r;
      mscratch_nxt_s    = mscratch_r;
      mcause_nxt_s      = mcause_r;
      mtval_nxt_s       = mtval_r;
      mcycle_nxt_s      = mcycle_r + 64'd1;
      minstret_nxt_s    = instr_ret_i ? (minstret_r + 64'd1) : minstret_r;
      redirect_nxt_s    = 1'b0;
      redirect_pc_nxt_s = redirect_pc_r;

      // A write to either counter half replaces it and suppresses that counter's increment.
      case (wr_addr_s)
         A_MSTATUS:   begin mie_nxt_s = csr_wdata_i[3]; mpie_nxt_s = csr_wdata_i[7]; end
         A_MTVEC:     mtvec_nxt_s    = csr_wdata_i[31:2];
         A_MSCRATCH:  mscratch_nxt_s = csr_wdata_i;
         A_MEPC:      mepc_nxt_s     = csr_wdata_i[31:2];
         A_MCAUSE:    mcause_nxt_s   = csr_wdata_i;
         A_MTVAL:     mtval_nxt_s    = csr_wdata_i;
         A_MCYCLE:    mcycle_nxt_s   = {mcycle_r[63:32], csr_wdata_i};
         A_MCYCLEH:   mcycle_nxt_s   = {csr_wdata_i, mcycle_r[31:0]};
         A_MINSTRET:  minstret_nxt_s = {minstret_r[63:32], csr_wdata_i};
         A_MINSTRETH: minstret_nxt_s = {csr_wdata_i, minstret_r[31:0]};
         default:     mie_nxt_s      = mie_r;
      endcase

      // Trap updates take priority over a same-cycle write; the vector uses pre-edge mtvec.
      case (trap_i)
         ECALL, EBREAK: begin
            mepc_nxt_s        = trap_pc_i[31:2];
            mcause_nxt_s      = (trap_i == ECALL) ? CAUSE_ECALL : CAUSE_EBRK;
            mtval_nxt_s       = (trap_i == ECALL) ? 32'h0 : trap_pc_i;
            mpie_nxt_s        = mie_r;
            mie_nxt_s         = 1'b0;
            redirect_nxt_s    = 1'b1;
            redirect_pc_nxt_s = {mtvec_r, 2'b00};
         end
         MRET: begin
            mie_nxt_s         = mpie_r;
            mpie_nxt_s        = 1'b1;
            redirect_nxt_s    = 1'b1;
            redirect_pc_nxt_s = {mepc_r, 2'b00};
         end
         default: redirect_nxt_s = 1'b0;
      endcase
   end

   // State registers; asynchronous reset also drops any pending redirect.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mie_r         <= 1'b0;
         mpie_r        <= 1'b0;
         mtvec_r       <= MTVEC_RESET[31:2];
         mepc_r        <= 30'h0;
         mscratch_r    <= 32'h0;
         mcause_r      <= 32'h0;
         mtval_r       <= 32'h0;
         mcycle_r      <= 64'h0;
         minstret_r    <= 64'h0;
         redirect_r    <= 1'b0;
         redirect_pc_r <= 32'h0;
      end else begin
         mie_r         <= mie_nxt_s;
         mpie_r        <= mpie_nxt_s;
         mtvec_r       <= mtvec_nxt_s;
         mepc_r        <= mepc_nxt_s;
         mscratch_r    <= mscratch_nxt_s;
         mcause_r      <= mcause_nxt_s;
         mtval_r       <= mtval_nxt_s;
         mcycle_r      <= mcycle_nxt_s;
         minstret_r    <= minstret_nxt_s;
         redirect_r    <= redirect_nxt_s;
         redirect_pc_r <= redirect_pc_nxt_s;
      end
   end

   // Combinational read mux with same-cycle write bypass for writable CSRs.
   always_comb begin
      case (csr_raddr_i)
         A_MSTATUS:             rd_reg_s = mstatus_view(mpie_r, mie_r);
         A_MISA:                rd_reg_s = MISA_VAL;
         A_MTVEC:               rd_reg_s = {mtvec_r, 2'b00};
         A_MSCRATCH:            rd_reg_s = mscratch_r;
         A_MEPC:                rd_reg_s = {mepc_r, 2'b00};
         A_MCAUSE:              rd_reg_s = mcause_r;
         A_MTVAL:               rd_reg_s = mtval_r;
         A_MCYCLE, A_CYCLE:     rd_reg_s = mcycle_r[31:0];
         A_MCYCLEH, A_CYCLEH:   rd_reg_s = mcycle_r[63:32];
         A_MINSTRET, A_INSTRET: rd_reg_s = minstret_r[31:0];
         A_MINSTRETH, A_INSTRETH: rd_reg_s = minstret_r[63:32];
         A_MHARTID:             rd_reg_s = HART_ID;
         default:               rd_reg_s = 32'h0;
      endcase
      byp_hit_s = csr_we_i && (csr_waddr_i == csr_raddr_i) && is_writable(csr_raddr_i);
      if (!csr_re_i) begin
         csr_rdata_o = 32'h0;
      end else if (byp_hit_s) begin
         csr_rdata_o = write_view(csr_raddr_i, csr_wdata_i);
      end else begin
         csr_rdata_o = rd_reg_s;
      end
   end

   assign redirect_o    = redirect_r;
   assign redirect_pc_o = redirect_pc_r;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit.
module tb_csr_unit;
   import csr_unit_pkg::*;

   localparam logic [31:0] HART  = 32'h0000_0005;
   localparam logic [31:0] TVEC0 = 32'h0000_0203;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        re = 1'b0;
   logic [11:0] raddr = 12'h0;
   logic [31:0] rdata;
   logic        we = 1'b0;
   logic [11:0] waddr = 12'h0;
   logic [31:0] wdata = 32'h0;
   logic        iret = 1'b0;
   exc_t        trap = NO_TRAP;
   logic [31:0] tpc = 32'h0;
   logic        redir;
   logic [31:0] redir_pc;

   int n_cmp = 0;
   int n_bad = 0;

   csr_unit #(.HART_ID(HART), .MTVEC_RESET(TVEC0)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .csr_re_i(re), .csr_raddr_i(raddr), .csr_rdata_o(rdata),
      .csr_we_i(we), .csr_waddr_i(waddr), .csr_wdata_i(wdata),
      .instr_ret_i(iret), .trap_i(trap), .trap_pc_i(tpc),
      .redirect_o(redir), .redirect_pc_o(redir_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Read a CSR on the combinational port and compare.
   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      re = 1'b1;
      raddr = a;
      #1;
      check(tag, rdata, exp);
      re = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      we = 1'b1;
      waddr = a;
      wdata = d;
   endtask

   initial begin
      cyc();
      check("rst_redir", {31'h0, redir}, 32'h0);
      check("rst_redir_pc", redir_pc, 32'h0);
      rstn = 1'b1;
      cyc();

      rd("rst_mstatus", 12'h300, 32'h0000_1800);
      rd("rst_misa", 12'h301, 32'h4000_0100);
      rd("rst_mhartid", 12'hF14, HART);
      rd("rst_mtvec", 12'h305, 32'h0000_0200);
      rd("unimpl_7c0", 12'h7C0, 32'h0);
      raddr = 12'h300; re = 1'b0; #1;
      check("re_low", rdata, 32'h0);

      // mstatus masking, with bypass in the write cycle
      wr(12'h300, 32'hFFFF_FFFF);
      rd("mstatus_byp", 12'h300, 32'h0000_1888);
      cyc(); we = 1'b0;
      rd("mstatus_wr", 12'h300, 32'h0000_1888);

      wr(12'h305, 32'h1234_5677);
      cyc(); we = 1'b0;
      rd("mtvec_wr", 12'h305, 32'h1234_5674);

      wr(12'h301, 32'h0000_0000);
      rd("misa_byp", 12'h301, 32'h4000_0100);
      cyc(); we = 1'b0;
      rd("misa_ro", 12'h301, 32'h4000_0100);

      wr(12'h340, 32'hAAAA_5555);
      rd("mscratch_byp", 12'h340, 32'hAAAA_5555);
      cyc(); we = 1'b0;
      rd("mscratch_wr", 12'h340, 32'hAAAA_5555);

      // MIE=1, MPIE=0 so the MPIE copy is visible; mtvec=0x100
      wr(12'h300, 32'h0000_0008);
      cyc();
      wr(12'h305, 32'h0000_0100);
      cyc(); we = 1'b0;

      trap = ECALL; tpc = 32'h0000_2000;
      cyc(); trap = NO_TRAP;
      check("ecall_redir", {31'h0, redir}, 32'h1);
      check("ecall_pc", redir_pc, 32'h0000_0100);
      rd("ecall_mepc", 12'h341, 32'h0000_2000);
      rd("ecall_mcause", 12'h342, 32'd11);
      rd("ecall_mtval", 12'h343, 32'h0);
      rd("ecall_mstatus", 12'h300, 32'h0000_1880);
      cyc();
      check("ecall_pulse_end", {31'h0, redir}, 32'h0);
      check("ecall_pc_hold", redir_pc, 32'h0000_0100);

      trap = MRET;
      cyc(); trap = NO_TRAP;
      check("mret_redir", {31'h0, redir}, 32'h1);
      check("mret_pc", redir_pc, 32'h0000_2000);
      rd("mret_mstatus", 12'h300, 32'h0000_1888);
      cyc();
      check("mret_pulse_end", {31'h0, redir}, 32'h0);

      // EBREAK with a same-cycle mtvec write, then ECALL with a same-cycle mcause write
      trap = EBREAK; tpc = 32'h0000_3006;
      wr(12'h305, 32'h0000_0400);
      cyc();
      trap = ECALL; tpc = 32'h0000_4000;
      wr(12'h342, 32'h0000_0077);
      check("ebrk_redir", {31'h0, redir}, 32'h1);
      check("ebrk_pc_old_tvec", redir_pc, 32'h0000_0100);
      rd("ebrk_mepc", 12'h341, 32'h0000_3004);
      rd("ebrk_mtval", 12'h343, 32'h0000_3006);
      rd("ebrk_mtvec", 12'h305, 32'h0000_0400);
      rd("ebrk_mstatus", 12'h300, 32'h0000_1880);
      cyc(); trap = NO_TRAP; we = 1'b0;
      check("b2b_redir", {31'h0, redir}, 32'h1);
      check("b2b_pc", redir_pc, 32'h0000_0400);
      rd("b2b_mcause", 12'h342, 32'd11);
      rd("b2b_mepc", 12'h341, 32'h0000_4000);
      cyc();
      check("b2b_pulse_end", {31'h0, redir}, 32'h0);

      // mcycle write, then mcycleh write suppressing the carry, then 2 idle cycles
      wr(12'hB00, 32'hFFFF_FFFF);
      cyc();
      wr(12'hB80, 32'h0000_0000);
      cyc(); we = 1'b0;
      rd("mcycle_held", 12'hB00, 32'hFFFF_FFFF);
      rd("mcycleh_wr", 12'hB80, 32'h0);
      cyc();
      cyc();
      rd("mcycleh_wrap", 12'hB80, 32'h0000_0001);
      rd("mcycle_wrap", 12'hB00, 32'h0000_0001);
      rd("cycleh_shadow", 12'hC80, 32'h0000_0001);
      rd("cycle_shadow", 12'hC00, 32'h0000_0001);

      // minstret write wins over a same-cycle retire, then wraps
      iret = 1'b1;
      wr(12'hB02, 32'hFFFF_FFFF);
      cyc(); we = 1'b0;
      rd("minstret_nowinc", 12'hB02, 32'hFFFF_FFFF);
      rd("minstreth_hold", 12'hB82, 32'h0);
      cyc(); iret = 1'b0;
      rd("minstret_wrap", 12'hB02, 32'h0);
      rd("minstreth_wrap", 12'hB82, 32'h0000_0001);
      rd("instret_shadow", 12'hC02, 32'h0);
      rd("instreth_shadow", 12'hC82, 32'h0000_0001);
      cyc();
      rd("minstret_idle", 12'hB02, 32'h0);

      // Asynchronous reset while a trap is being presented
      trap = ECALL; tpc = 32'h0000_5000;
      #2 rstn = 1'b0;
      #1;
      check("async_redir_pc", redir_pc, 32'h0);
      rd("async_mstatus", 12'h300, 32'h0000_1800);
      rd("async_mtvec", 12'h305, 32'h0000_0200);
      rd("async_mscratch", 12'h340, 32'h0);
      rd("async_mcycleh", 12'hB80, 32'h0);
      trap = NO_TRAP;
      cyc();
      rstn = 1'b1;
      cyc();
      check("async_no_redir", {31'h0, redir}, 32'h0);
      rd("async_mepc", 12'h341, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
